// File: rtl/grid_idprobe.sv
// Avalon-MM probe master: reads the four-word ID window after reset or on request,
// checks each word against its signature and reports the verdict via a status slave.
module grid_idprobe #(
    parameter logic [31:0] EXP_ID1      = 32'hA5A5A5A5,
    parameter logic [31:0] EXP_ID3      = 32'h5A5A5A5A,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    output logic [1:0]  avm_Probe_address,
    output logic        avm_Probe_read,
    input  logic [31:0] avm_Probe_readdata,
    input  logic        avm_Probe_waitrequest,
    input  logic        avs_Status_address,
    input  logic        avs_Status_read,
    input  logic        avs_Status_write,
    input  logic [31:0] avs_Status_writedata,
    output logic [31:0] avs_Status_readdata,
    output logic        avs_Status_waitrequest,
    output logic        coe_id_ok
);

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(3);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0]   run_count, run_count_n;
    logic               pass, pass_n;
    logic               mismatch, mismatch_n;
    logic               timeout, timeout_n;
    logic [IDX_W-1:0]   fail_index, fail_index_n;
    logic [DATA_W-1:0]  fail_data, fail_data_n;
    logic               read_n;
    logic [IDX_W-1:0]   address_n;
    logic               busy;
    logic               restart;

    // Expected signature for each word of the ID window
    function automatic logic [DATA_W-1:0] exp_word(input logic [IDX_W-1:0] i);
        case (i)
            2'd1:    exp_word = EXP_ID1;
            2'd3:    exp_word = EXP_ID3;
            default: exp_word = '0;
        endcase
    endfunction

    assign busy    = (state == S_START) || (state == S_REQ);
    assign restart = avs_Status_write && !avs_Status_address && avs_Status_writedata[0];

    // Next-state and next-register values
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        wait_cnt_n   = wait_cnt;
        run_count_n  = run_count;
        pass_n       = pass;
        mismatch_n   = mismatch;
        timeout_n    = timeout;
        fail_index_n = fail_index;
        fail_data_n  = fail_data;

        case (state)
            S_START: begin
                state_n    = S_REQ;
                idx_n      = '0;
                wait_cnt_n = '0;
            end
            S_REQ: begin
                if (!avm_Probe_waitrequest) begin
                    wait_cnt_n = '0;
                    if (avm_Probe_readdata == exp_word(idx)) begin
                        if (idx == IDX_LAST) begin
                            state_n     = S_DONE;
                            pass_n      = 1'b1;
                            run_count_n = run_count + CNT_W'(1);
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        state_n      = S_FAIL;
                        mismatch_n   = 1'b1;
                        fail_index_n = idx;
                        fail_data_n  = avm_Probe_readdata;
                        run_count_n  = run_count + CNT_W'(1);
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n      = S_FAIL;
                    timeout_n    = 1'b1;
                    fail_index_n = idx;
                    fail_data_n  = '0;
                    run_count_n  = run_count + CNT_W'(1);
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            S_DONE, S_FAIL: begin
                if (restart) begin
                    state_n      = S_START;
                    pass_n       = 1'b0;
                    mismatch_n   = 1'b0;
                    timeout_n    = 1'b0;
                    fail_index_n = '0;
                    fail_data_n  = '0;
                end
            end
            default: state_n = S_START;
        endcase

        read_n    = (state_n == S_REQ);
        address_n = (state_n == S_REQ) ? idx_n : '0;
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset) begin
        if (!rsi_MRST_reset) begin
            state             <= S_START;
            idx               <= '0;
            wait_cnt          <= '0;
            run_count         <= '0;
            pass              <= 1'b0;
            mismatch          <= 1'b0;
            timeout           <= 1'b0;
            fail_index        <= '0;
            fail_data         <= '0;
            avm_Probe_read    <= 1'b0;
            avm_Probe_address <= '0;
        end else begin
            state             <= state_n;
            idx               <= idx_n;
            wait_cnt          <= wait_cnt_n;
            run_count         <= run_count_n;
            pass              <= pass_n;
            mismatch          <= mismatch_n;
            timeout           <= timeout_n;
            fail_index        <= fail_index_n;
            fail_data         <= fail_data_n;
            avm_Probe_read    <= read_n;
            avm_Probe_address <= address_n;
        end
    end

    // Zero-wait status slave, read data muxed straight from the registers
    always_comb begin
        avs_Status_readdata = '0;
        if (avs_Status_address) begin
            avs_Status_readdata = fail_data;
        end else begin
            avs_Status_readdata = {16'h0000, run_count, 2'b00, fail_index,
                                   busy, timeout, mismatch, pass};
        end
    end

    assign avs_Status_waitrequest = 1'b0;
    assign coe_id_ok              = pass;

    logic unused_status;
    assign unused_status = &{1'b0, avs_Status_read, avs_Status_writedata[31:1]};

endmodule

// File: tb/tb_grid_idprobe.sv
// Randomized bench for grid_idprobe: a stalling ID-slave responder plus a
// transaction-level model predicting verdict, duration and status contents.
module tb_grid_idprobe;

    localparam int unsigned WT = 4;
    localparam logic [31:0] ID1 = 32'hA5A5A5A5;
    localparam logic [31:0] ID3 = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  p_address;
    logic        p_read;
    logic [31:0] p_readdata = '0;
    logic        p_waitreq = 1'b0;
    logic        s_address = 1'b0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        s_waitreq;
    logic        id_ok;

    grid_idprobe #(.EXP_ID1(ID1), .EXP_ID3(ID3), .WAIT_TIMEOUT(WT)) dut (
        .csi_MCLK_clk          (clk),
        .rsi_MRST_reset        (rst_n),
        .avm_Probe_address     (p_address),
        .avm_Probe_read        (p_read),
        .avm_Probe_readdata    (p_readdata),
        .avm_Probe_waitrequest (p_waitreq),
        .avs_Status_address    (s_address),
        .avs_Status_read       (s_read),
        .avs_Status_write      (s_write),
        .avs_Status_writedata  (s_writedata),
        .avs_Status_readdata   (s_readdata),
        .avs_Status_waitrequest(s_waitreq),
        .coe_id_ok             (id_ok)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responder configuration for the current probe
    logic [31:0] rsp_data [4];
    int          rsp_stall[4];
    int          scnt = 0;
    int          viol = 0;
    int          last_rd = 0;
    int          acc_q[$];

    // ID slave responder: stalls each word rsp_stall[] cycles, then returns its data
    always @(negedge clk) begin
        if (!rst_n) begin
            p_waitreq = 1'b0;
            scnt = 0;
        end else if (p_read) begin
            last_rd = int'(p_address);
            if (scnt < rsp_stall[p_address]) begin
                p_waitreq  = 1'b1;
                p_readdata = $urandom;
                scnt++;
            end else begin
                p_waitreq  = 1'b0;
                p_readdata = rsp_data[p_address];
                acc_q.push_back(int'(p_address));
                scnt = 0;
            end
        end else begin
            p_waitreq = 1'b0;
            scnt = 0;
            if (p_address != 2'd0) viol++;
        end
    end

    // Model prediction
    int          m_kind;   // 0 pass, 1 mismatch, 2 timeout
    int          m_idx;
    logic [31:0] m_data;
    int          m_cycles;
    int          m_nacc;
    int          m_last;
    logic [7:0]  m_rc = 8'd0;

    function automatic logic [31:0] sig(input int i);
        case (i)
            1: sig = ID1;
            3: sig = ID3;
            default: sig = 32'h0;
        endcase
    endfunction

    task automatic set_clean();
        for (int i = 0; i < 4; i++) begin
            rsp_data[i]  = sig(i);
            rsp_stall[i] = 0;
        end
    endtask

    task automatic prep_probe();
        bit done;
        done = 0;
        m_kind = 0; m_idx = 0; m_data = 32'h0; m_cycles = 1; m_nacc = 4; m_last = 3;
        for (int w = 0; w < 4; w++) begin
            if (!done) begin
                if (rsp_stall[w] >= int'(WT)) begin
                    m_cycles += int'(WT);
                    m_kind = 2; m_idx = w; m_nacc = w; m_last = w; done = 1;
                end else begin
                    m_cycles += rsp_stall[w] + 1;
                    if (rsp_data[w] != sig(w)) begin
                        m_kind = 1; m_idx = w; m_data = rsp_data[w];
                        m_nacc = w + 1; m_last = w; done = 1;
                    end
                end
            end
        end
        acc_q.delete();
        viol = 0;
        last_rd = -1;
    endtask

    function automatic logic [31:0] exp_st0();
        exp_st0 = {16'h0, m_rc, 2'b00, 2'(m_idx), 1'b0,
                   1'(m_kind == 2), 1'(m_kind == 1), 1'(m_kind == 0)};
    endfunction

    task automatic read_status(input logic a, output logic [31:0] v);
        s_address = a;
        s_read = 1'b1;
        #1;
        v = s_readdata;
        s_read = 1'b0;
        s_address = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        s_address = 1'b0; s_writedata = 32'h1; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0; s_writedata = 32'h0;
    endtask

    // Call at a negedge where the probe has just started (state START)
    task automatic finish_probe(input string tag, input bit wr_busy);
        logic [31:0] st;
        int cnt, guard;
        cnt = 0; guard = 0;
        read_status(1'b0, st);
        while (st[3] && guard < 2000) begin
            cnt++;
            if (wr_busy) begin
                s_address = 1'b0; s_writedata = 32'h1; s_write = 1'b1;
            end
            @(negedge clk);
            s_write = 1'b0;
            read_status(1'b0, st);
            guard++;
        end
        s_write = 1'b0; s_writedata = 32'h0;
        if (guard >= 2000) check({tag, "_wait_bound"}, 32'(guard), 32'd0);
        m_rc = m_rc + 8'd1;
        check({tag, "_cycles"}, 32'(cnt), 32'(m_cycles));
        check({tag, "_st0"}, st, exp_st0());
        read_status(1'b1, st);
        check({tag, "_st1"}, st, m_data);
        check({tag, "_id_ok"}, 32'(id_ok), 32'(m_kind == 0));
        check({tag, "_nacc"}, 32'(acc_q.size()), 32'(m_nacc));
        for (int i = 0; i < acc_q.size() && i < 4; i++)
            check({tag, "_acc_addr"}, 32'(acc_q[i]), 32'(i));
        check({tag, "_last_rd"}, 32'(last_rd), 32'(m_last));
        check({tag, "_idle_addr"}, 32'(viol), 32'd0);
        check({tag, "_read_idle"}, 32'(p_read), 32'd0);
    endtask

    initial begin
        logic [31:0] st;
        int cnt;
        set_clean();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_read", 32'(p_read), 32'd0);
        check("rst_addr", 32'(p_address), 32'd0);
        read_status(1'b0, st);
        check("rst_st0", st, 32'h0000_0008);
        read_status(1'b1, st);
        check("rst_st1", st, 32'h0);
        check("rst_id_ok", 32'(id_ok), 32'd0);
        check("rst_swait", 32'(s_waitreq), 32'd0);

        // Zero-wait probe straight out of reset
        prep_probe();
        @(negedge clk);
        rst_n = 1'b1;
        finish_probe("zero_wait", 1'b0);

        // Writes that must not restart: address 1, and address 0 with bit0 clear
        @(negedge clk);
        s_address = 1'b1; s_writedata = 32'h1; s_write = 1'b1;
        @(negedge clk);
        s_address = 1'b0; s_writedata = 32'hFFFF_FFFE;
        @(negedge clk);
        s_write = 1'b0; s_writedata = 32'h0;
        read_status(1'b0, st);
        check("ignored_wr_st0", st, exp_st0());

        // Three stalls on word 2
        set_clean(); rsp_stall[2] = 3;
        prep_probe(); pulse_restart(); finish_probe("stall_w2", 1'b0);

        // Corrupted word 1
        set_clean(); rsp_data[1] = 32'hA5A5A5A4;
        prep_probe(); pulse_restart(); finish_probe("bad_w1", 1'b0);

        // Stuck waitrequest on word 0
        set_clean(); rsp_stall[0] = 1000;
        prep_probe(); pulse_restart(); finish_probe("timeout_w0", 1'b0);

        // Longest stall that still completes, and shortest that times out
        set_clean(); rsp_stall[3] = int'(WT) - 1;
        prep_probe(); pulse_restart(); finish_probe("stall_max", 1'b0);
        set_clean(); rsp_stall[1] = int'(WT);
        prep_probe(); pulse_restart(); finish_probe("stall_lim", 1'b0);

        // Restart writes on every busy edge, including the final accept, are ignored
        set_clean(); rsp_stall[1] = 2;
        prep_probe(); pulse_restart(); finish_probe("wr_busy", 1'b1);

        // Randomized probes
        for (int it = 0; it < 40; it++) begin
            set_clean();
            for (int i = 0; i < 4; i++)
                rsp_stall[i] = ($urandom_range(0, 7) == 0) ? int'(WT) + int'($urandom_range(0, 2))
                                                            : int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, 3));
                rsp_data[k] = rsp_data[k] ^ (32'h1 << $urandom_range(0, 31));
            end
            prep_probe(); pulse_restart();
            finish_probe("rand", ($urandom_range(0, 3) == 0));
        end

        // Reset during a stalled word 1, then a clean rerun
        set_clean(); rsp_stall[1] = 1000;
        prep_probe(); pulse_restart();
        cnt = 0;
        while (!(p_read && p_address == 2'd1) && cnt < 50) begin
            @(negedge clk); cnt++;
        end
        check("midrst_reach_w1", 32'(p_read && p_address == 2'd1), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_read", 32'(p_read), 32'd0);
        check("midrst_addr", 32'(p_address), 32'd0);
        read_status(1'b0, st);
        check("midrst_st0", st, 32'h0000_0008);
        read_status(1'b1, st);
        check("midrst_st1", st, 32'h0);
        check("midrst_id_ok", 32'(id_ok), 32'd0);
        m_rc = 8'd0;
        set_clean();
        repeat (2) @(negedge clk);
        prep_probe();
        rst_n = 1'b1;
        finish_probe("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_idprobe.md
# grid_idprobe

Avalon-MM master that probes a CloseID-style ID slave, a four-word read-only window with the expected map 0x0, 0xA5A5A5A5, 0x0, 0x5A5A5A5A. After reset, and again on software request, it reads all four words in order and checks each against its expected signature. It reports pass, mismatch or timeout through a small Avalon-MM status slave and a conduit flag. It sits in the Qsys system beside the ID slave and lets the board logic gate its bring-up on a verified fabric.

## Interface
Parameters:
- EXP_ID1, 32'hA5A5A5A5, expected word at address 1
- EXP_ID3, 32'h5A5A5A5A, expected word at address 3
- WAIT_TIMEOUT, 255, max consecutive waitrequest cycles per word (1..255)

Ports:
- csi_MCLK_clk  in  1  system clock; single clock domain
- rsi_MRST_reset  in  1  reset, asynchronous, active-low
- avm_Probe_address  out  2  word address to ID slave
- avm_Probe_read  out  1  read strobe
- avm_Probe_readdata  in  32  read data, valid on accept cycle
- avm_Probe_waitrequest  in  1  slave stall
- avs_Status_address  in  1  status register select
- avs_Status_read  in  1  status read strobe
- avs_Status_write  in  1  status write strobe
- avs_Status_writedata  in  32  write data
- avs_Status_readdata  out  32  status read data
- avs_Status_waitrequest  out  1  tied 0
- coe_id_ok  out  1  conduit: last probe passed

## Operation
- FSM states: START, REQ, DONE, FAIL.
  - Reset enters START.
  - START goes to REQ on the next edge, with word index = 0.
- REQ behaviour:
  - avm_Probe_read = 1 and avm_Probe_address = word index; both are held stable while waitrequest = 1.
  - A word is accepted on an edge where read = 1 and waitrequest = 0. readdata is compared on that edge (zero read latency, no readdatavalid).
- Expected values by index: 0 → 0x0, 1 → EXP_ID1, 2 → 0x0, 3 → EXP_ID3.
- On accept, match and index < 3: the index increments and the FSM stays in REQ. read stays high, so back-to-back words take 1 cycle each.
- On accept, match and index = 3: go to DONE; set pass.
- On accept and mismatch: go to FAIL.
  - Set mismatch.
  - fail_index = index.
  - fail_data = readdata.
- Timeout handling:
  - The wait counter (8-bit) clears on every accept and on entering REQ.
  - It increments each REQ cycle with waitrequest = 1.
  - When it reaches WAIT_TIMEOUT, go to FAIL: set timeout, fail_index = index, fail_data = 0. read drops on the same edge.
- run_count: 8-bit, increments on every entry to DONE or FAIL and wraps 255 → 0.
- Outputs by state:
  - read = 0 outside REQ.
  - address = 0 outside REQ.
- Status register map:
  - Address 0: bit0 pass, bit1 mismatch, bit2 timeout, bit3 busy (state is START or REQ), bits5:4 fail_index, bits15:8 run_count, all other bits 0.
  - Address 1: fail_data.
  - readdata is a combinational mux on address.
- Restart:
  - A write to address 0 with writedata[0] = 1 while in DONE or FAIL clears pass, mismatch, timeout, fail_index and fail_data, and goes to START.
  - The same write while busy is ignored.
  - Writes to address 1 are ignored.
- coe_id_ok equals pass.

## Timing
- Reset values, applied asynchronously on rsi_MRST_reset = 0:
  - avm_Probe_read = 0, address = 0.
  - pass, mismatch, timeout = 0; fail_index = 0, fail_data = 0, run_count = 0.
  - coe_id_ok = 0.
  - State START.
- Reset asserted mid-transfer: read drops immediately, with no completion and no run_count change.
- Zero-wait probe after reset release:
  - Edge 1: START → REQ; read high from edge 1.
  - Edges 2–5: accept words 0–3.
  - After edge 5: pass = 1, busy = 0, read = 0. Total 5 cycles.
- Each waitrequest cycle adds exactly 1 cycle to its word.
- A timeout asserts after exactly WAIT_TIMEOUT stalled cycles on one word.
- Restart write on edge N: busy = 1 after edge N; read is asserted after edge N+1.
- A restart write on the same edge as the final accept is ignored, because the FSM is busy at that edge. The probe completes normally.
- Status reads: zero wait state; readdata reflects register values as of the current cycle.

## Test plan
- Zero-wait responder with the correct map; release reset → read high cycles 1–4, addresses 0,1,2,3; pass = 1 after edge 5; status addr0 = 0x0000_0101; coe_id_ok = 1.
- Responder with 3 waitrequest cycles on address 2 → address held at 2 for 4 cycles; pass after edge 8; run_count = 1.
- Responder returns 0xA5A5A5A4 at address 1 → FAIL after the second accept; status addr0 = 0x0000_0112; addr1 = 0xA5A5A5A4; no read issued to address 2; coe_id_ok = 0.
- waitrequest stuck high at address 0 with WAIT_TIMEOUT = 4 → timeout after 4 stall cycles; status addr0 = 0x0000_0104; addr1 = 0.
- After a FAIL, write addr0 = 1 with the responder fixed → flags clear, busy observed, pass = 1, run_count = 2. A write during busy does not restart the probe.
- Assert reset during stalled word 1 → read = 0 and all status = 0 immediately. After release, the full probe reruns from address 0.
